// File: rtl/cfg_router_pkg.sv
// Shared types and constants for the wishbone config router and its register file.
package cfg_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_SLV  = 3'd2,
        ST_ERR  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam int          STAT_TMO_BIT    = 0;
    localparam int          STAT_DEC_BIT    = 1;
    localparam logic [31:0] ERR_DAT_DEFAULT = 32'hDEADBEEF;

    function automatic logic region_hit(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/cfg_router_regfile.sv
// Byte-writable config registers plus the sticky error status word (write-1-to-clear, set wins).
module cfg_router_regfile
    import cfg_router_pkg::*;
#(
    parameter int          NUM_CFG  = 4,
    parameter logic [31:0] CFG_INIT = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [3:0]            idx_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           wdat_i,
    input  logic                  set_tmo_i,
    input  logic                  set_dec_i,
    output logic [31:0]           rd_dat_o,
    output logic [32*NUM_CFG-1:0] cfg_out_o,
    output logic                  err_tmo_o,
    output logic                  err_dec_o
);

    localparam logic [3:0] STAT_IDX = 4'(NUM_CFG);

    logic err_tmo_q, err_tmo_d;
    logic err_dec_q, err_dec_d;
    logic stat_clr;

    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_reg
        logic [31:0] reg_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= CFG_INIT;
            end else if (wr_en_i && (idx_i == 4'(gi))) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_i[b]) begin
                        reg_q[8*b +: 8] <= wdat_i[8*b +: 8];
                    end
                end
            end
        end

        assign cfg_out_o[32*gi +: 32] = reg_q;
    end

    // Status clears need byte lane 0 selected; a fresh error in the same cycle overrides the clear.
    assign stat_clr  = wr_en_i && (idx_i == STAT_IDX) && sel_i[0];
    assign err_tmo_d = set_tmo_i | (err_tmo_q & ~(stat_clr & wdat_i[STAT_TMO_BIT]));
    assign err_dec_d = set_dec_i | (err_dec_q & ~(stat_clr & wdat_i[STAT_DEC_BIT]));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_tmo_q <= 1'b0;
            err_dec_q <= 1'b0;
        end else begin
            err_tmo_q <= err_tmo_d;
            err_dec_q <= err_dec_d;
        end
    end

    always_comb begin
        rd_dat_o = '0;
        if (idx_i == STAT_IDX) begin
            rd_dat_o[STAT_TMO_BIT] = err_tmo_q;
            rd_dat_o[STAT_DEC_BIT] = err_dec_q;
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (idx_i == 4'(i)) begin
                rd_dat_o = cfg_out_o[32*i +: 32];
            end
        end
    end

    assign err_tmo_o = err_tmo_q;
    assign err_dec_o = err_dec_q;

endmodule

// File: rtl/cfg_router.sv
// Wishbone command router: one outstanding command, decoded to the local config file or one of NUM_SLV slaves.
module cfg_router
    import cfg_router_pkg::*;
#(
    parameter int          NUM_SLV    = 4,
    parameter int          NUM_CFG    = 4,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFF0000,
    parameter logic [31:0] CFG_ADDR   = 32'h00000000,
    parameter logic [31:0] SLV_BASE   = 32'h00010000,
    parameter logic [31:0] SLV_STRIDE = 32'h00010000,
    parameter logic [31:0] CFG_INIT   = 32'h0,
    parameter int          TMO_CYC    = 255,
    parameter logic [31:0] ERR_DAT    = ERR_DAT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cmd_val,
    input  logic [31:0]           wb_cmd_adr,
    input  logic                  wb_cmd_we,
    input  logic [3:0]            wb_cmd_sel,
    input  logic [31:0]           wb_cmd_dat,
    output logic                  cmd_rdy,
    output logic                  wb_rd_ack,
    output logic [31:0]           wb_rd_dat,
    output logic [31:0]           cmd_adr,
    output logic                  cmd_we,
    output logic [3:0]            cmd_sel,
    output logic [31:0]           cmd_dat,
    output logic [NUM_SLV-1:0]    slv_cmd_val,
    input  logic [NUM_SLV-1:0]    slv_rd_ack,
    input  logic [32*NUM_SLV-1:0] slv_rd_dat,
    output logic [32*NUM_CFG-1:0] cfg_out,
    output logic                  err_tmo,
    output logic                  err_dec
);

    localparam int TW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [TW-1:0] tgt_q, tgt_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic [31:0]   cmd_adr_q, cmd_dat_q;
    logic          cmd_we_q;
    logic [3:0]    cmd_sel_q;

    logic               accept;
    logic               cfg_hit;
    logic [NUM_SLV-1:0] slv_hit;
    logic               slv_any;
    logic [TW-1:0]      slv_idx;
    logic               tgt_ack;
    logic [31:0]        tgt_dat;
    logic               set_tmo, set_dec;
    logic [31:0]        rf_rd_dat;

    assign accept  = wb_cmd_val && (state_q == ST_IDLE);
    assign cfg_hit = region_hit(wb_cmd_adr, CFG_ADDR, ADDR_MASK);

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        localparam logic [31:0] BASE = SLV_BASE + 32'(gi) * SLV_STRIDE;
        assign slv_hit[gi]     = region_hit(wb_cmd_adr, BASE, ADDR_MASK);
        assign slv_cmd_val[gi] = (state_q == ST_SLV) && (timer_q == 8'd0) && (tgt_q == TW'(gi));
    end

    // Descending scan so the lowest matching slave is the one left standing.
    always_comb begin
        slv_any = |slv_hit;
        slv_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (slv_hit[i]) begin
                slv_idx = TW'(i);
            end
        end
    end

    always_comb begin
        tgt_ack = 1'b0;
        tgt_dat = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (tgt_q == TW'(i)) begin
                tgt_ack = slv_rd_ack[i];
                tgt_dat = slv_rd_dat[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tgt_d     = tgt_q;
        rsp_dat_d = rsp_dat_q;
        set_tmo   = 1'b0;
        set_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    timer_d = 8'd0;
                    if (cfg_hit) begin
                        state_d = ST_CFG;
                    end else if (slv_any) begin
                        state_d = ST_SLV;
                        tgt_d   = slv_idx;
                    end else begin
                        state_d = ST_ERR;
                        set_dec = 1'b1;
                    end
                end
            end
            ST_SLV: begin
                // A real ack on the timeout cycle takes priority over the error.
                if (tgt_ack) begin
                    rsp_dat_d = cmd_we_q ? 32'h0 : tgt_dat;
                    state_d   = ST_RESP;
                end else if (timer_q == 8'(TMO_CYC)) begin
                    rsp_dat_d = ERR_DAT;
                    set_tmo   = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= 8'd0;
            tgt_q     <= '0;
            rsp_dat_q <= '0;
            cmd_adr_q <= '0;
            cmd_we_q  <= 1'b0;
            cmd_sel_q <= '0;
            cmd_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tgt_q     <= tgt_d;
            rsp_dat_q <= rsp_dat_d;
            if (accept) begin
                cmd_adr_q <= wb_cmd_adr;
                cmd_we_q  <= wb_cmd_we;
                cmd_sel_q <= wb_cmd_sel;
                cmd_dat_q <= wb_cmd_dat;
            end
        end
    end

    cfg_router_regfile #(
        .NUM_CFG  (NUM_CFG),
        .CFG_INIT (CFG_INIT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   ((state_q == ST_CFG) && cmd_we_q),
        .idx_i     (cmd_adr_q[5:2]),
        .sel_i     (cmd_sel_q),
        .wdat_i    (cmd_dat_q),
        .set_tmo_i (set_tmo),
        .set_dec_i (set_dec),
        .rd_dat_o  (rf_rd_dat),
        .cfg_out_o (cfg_out),
        .err_tmo_o (err_tmo),
        .err_dec_o (err_dec)
    );

    always_comb begin
        wb_rd_ack = 1'b0;
        wb_rd_dat = '0;
        case (state_q)
            ST_CFG: begin
                wb_rd_ack = 1'b1;
                if (!cmd_we_q) wb_rd_dat = rf_rd_dat;
            end
            ST_ERR: begin
                wb_rd_ack = 1'b1;
                if (!cmd_we_q) wb_rd_dat = ERR_DAT;
            end
            ST_RESP: begin
                wb_rd_ack = 1'b1;
                wb_rd_dat = rsp_dat_q;
            end
            default: ;
        endcase
    end

    assign cmd_rdy = (state_q == ST_IDLE);
    assign cmd_adr = cmd_adr_q;
    assign cmd_we  = cmd_we_q;
    assign cmd_sel = cmd_sel_q;
    assign cmd_dat = cmd_dat_q;

endmodule

// File: tb/tb_cfg_router.sv
// Directed and randomized transactions against a region/timing reference model of the router.
module tb_cfg_router;

    localparam int NS  = 4;
    localparam int NC  = 4;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_cmd_val;
    logic [31:0]     wb_cmd_adr;
    logic            wb_cmd_we;
    logic [3:0]      wb_cmd_sel;
    logic [31:0]     wb_cmd_dat;
    logic            cmd_rdy;
    logic            wb_rd_ack;
    logic [31:0]     wb_rd_dat;
    logic [31:0]     cmd_adr;
    logic            cmd_we;
    logic [3:0]      cmd_sel;
    logic [31:0]     cmd_dat;
    logic [NS-1:0]   slv_cmd_val;
    logic [NS-1:0]   slv_rd_ack;
    logic [32*NS-1:0] slv_rd_dat;
    logic [32*NC-1:0] cfg_out;
    logic            err_tmo;
    logic            err_dec;

    always #5 clk = ~clk;

    cfg_router #(.NUM_SLV(NS), .NUM_CFG(NC), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .wb_cmd_val(wb_cmd_val), .wb_cmd_adr(wb_cmd_adr), .wb_cmd_we(wb_cmd_we),
        .wb_cmd_sel(wb_cmd_sel), .wb_cmd_dat(wb_cmd_dat),
        .cmd_rdy(cmd_rdy), .wb_rd_ack(wb_rd_ack), .wb_rd_dat(wb_rd_dat),
        .cmd_adr(cmd_adr), .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
        .slv_cmd_val(slv_cmd_val), .slv_rd_ack(slv_rd_ack), .slv_rd_dat(slv_rd_dat),
        .cfg_out(cfg_out), .err_tmo(err_tmo), .err_dec(err_dec)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_cfg [NC];
    logic        m_tmo, m_dec;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_cfg();
        logic [127:0] v = '0;
        for (int i = 0; i < NC; i++) v[32*i +: 32] = m_cfg[i];
        return v;
    endfunction

    // One command end to end; dly = cycles from strobe to target ack (negative = never).
    task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input int dly, input logic [31:0] sdat);
        int          hi, idx, tgt, exp_lat, got_lat, extra;
        logic [31:0] exp_dat, got_dat;
        logic [NS-1:0] exp_strb, got_strb, ack_v;
        logic        got;
        int          w;

        hi = int'(adr >> 16);
        idx = int'(adr[5:2]);
        tgt = -1;
        exp_strb = '0;
        exp_dat = 32'h0;
        exp_lat = 1;
        if (hi == 0) begin
            if (idx < NC) begin
                if (!we) exp_dat = m_cfg[idx];
                else for (int b = 0; b < 4; b++) if (sel[b]) m_cfg[idx][8*b +: 8] = dat[8*b +: 8];
            end else if (idx == NC) begin
                if (!we) exp_dat = {30'b0, m_dec, m_tmo};
                else if (sel[0]) begin
                    if (dat[0]) m_tmo = 1'b0;
                    if (dat[1]) m_dec = 1'b0;
                end
            end
        end else if (hi <= NS) begin
            tgt = hi - 1;
            exp_strb = NS'(1) << tgt;
            if (dly >= 0 && dly <= TMO) begin
                exp_lat = 2 + dly;
                exp_dat = we ? 32'h0 : sdat;
            end else begin
                exp_lat = TMO + 2;
                exp_dat = 32'hDEADBEEF;
                m_tmo = 1'b1;
            end
        end else begin
            exp_dat = we ? 32'h0 : 32'hDEADBEEF;
            m_dec = 1'b1;
        end

        for (int i = 0; i < NS; i++) slv_rd_dat[32*i +: 32] = (i == tgt) ? sdat : $urandom;
        w = 0;
        while (!cmd_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "/rdy"}, 128'(cmd_rdy), 128'(1));
        wb_cmd_val = 1'b1;
        wb_cmd_adr = adr;
        wb_cmd_we  = we;
        wb_cmd_sel = sel;
        wb_cmd_dat = dat;
        @(negedge clk);
        wb_cmd_val = 1'b0;

        got = 1'b0; got_lat = 0; got_dat = '0; got_strb = '0; extra = 0;
        for (int k = 1; k <= 30 && !got; k++) begin
            if (k > 1) @(negedge clk);
            ack_v = NS'($urandom);
            if (tgt >= 0) begin
                ack_v &= ~(NS'(1) << tgt);
                if (k == 1 + dly) ack_v |= NS'(1) << tgt;
            end
            slv_rd_ack = ack_v;
            if (k == 1) got_strb = slv_cmd_val;
            else if (slv_cmd_val != '0) extra++;
            if (wb_rd_ack) begin
                got = 1'b1;
                got_lat = k;
                got_dat = wb_rd_dat;
            end
        end
        slv_rd_ack = '0;
        chk({tag, "/ack_latency"}, 128'(got_lat), 128'(exp_lat));
        chk({tag, "/rd_dat"}, 128'(got_dat), 128'(exp_dat));
        chk({tag, "/strobe"}, 128'(got_strb), 128'(exp_strb));
        chk({tag, "/extra_strobe"}, 128'(extra), 128'(0));
        @(negedge clk);
        chk({tag, "/ack_single"}, 128'(wb_rd_ack), 128'(0));
        chk({tag, "/rdy_after"}, 128'(cmd_rdy), 128'(1));
        chk({tag, "/err_flags"}, 128'({err_dec, err_tmo}), 128'({m_dec, m_tmo}));
        chk({tag, "/cfg_out"}, 128'(cfg_out), model_cfg());
        chk({tag, "/cmd_copy"}, 128'({cmd_adr, cmd_we, cmd_sel, cmd_dat}), 128'({adr, we, sel, dat}));
        $display("txn %s adr=%08h we=%0d lat=%0d dat=%08h", tag, adr, we, got_lat, got_dat);
    endtask

    initial begin
        logic [31:0] adr;
        int          r;

        rst = 1'b1;
        wb_cmd_val = 1'b0; wb_cmd_adr = '0; wb_cmd_we = 1'b0; wb_cmd_sel = '0; wb_cmd_dat = '0;
        slv_rd_ack = '0; slv_rd_dat = '0;
        for (int i = 0; i < NC; i++) m_cfg[i] = 32'h0;
        m_tmo = 1'b0; m_dec = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/rdy", 128'(cmd_rdy), 128'(1));
        chk("reset/ack", 128'({wb_rd_ack, wb_rd_dat}), 128'(0));
        chk("reset/strobe", 128'(slv_cmd_val), 128'(0));
        chk("reset/cmd_copy", 128'({cmd_adr, cmd_we, cmd_sel, cmd_dat}), 128'(0));
        chk("reset/cfg_out", 128'(cfg_out), 128'(0));
        chk("reset/errs", 128'({err_dec, err_tmo}), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        run_txn("cfg_wr_partial", 32'h4, 1'b1, 4'b0011, 32'hA5A5A5A5, 0, 32'h0);
        run_txn("cfg_rd_back", 32'h4, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        chk("cfg_rd_back/literal", 128'(m_cfg[1]), 128'(32'h0000A5A5));
        run_txn("slv2_rd", 32'h00030010, 1'b0, 4'hF, 32'h0, 3, 32'h12345678);
        run_txn("slv0_timeout", 32'h00010000, 1'b0, 4'hF, 32'h0, -1, 32'h0);
        run_txn("status_rd", 32'h10, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        run_txn("status_clr", 32'h10, 1'b1, 4'hF, 32'h1, 0, 32'h0);
        run_txn("dec_err", 32'hFFFF0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        run_txn("ack_on_tmo_cycle", 32'h00040008, 1'b0, 4'hF, 32'h0, TMO, 32'hCAFEF00D);

        for (int c = 0; c < 4; c++) begin
            slv_rd_ack = NS'($urandom) | NS'(1);
            @(negedge clk);
            chk("stray_ack/no_ack", 128'({wb_rd_ack, cmd_rdy}), 128'(2'b01));
        end
        slv_rd_ack = '0;

        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) adr = ($urandom & 32'h0000FFC0) | (32'($urandom_range(0, 6)) << 2);
            else if (r < 8) adr = (32'($urandom_range(1, NS)) << 16) | ($urandom & 32'h0000FFFC);
            else if (r == 8) adr = (32'($urandom_range(NS + 1, 16'hFFFF)) << 16) | ($urandom & 32'hFFFF);
            else adr = 32'h10;
            run_txn("rand", adr, 1'($urandom), 4'($urandom), $urandom,
                    int'($urandom_range(0, TMO + 2)), $urandom);
        end

        // Reset in the middle of a slave wait: nothing may complete, late acks are dropped.
        chk("rst_mid/rdy", 128'(cmd_rdy), 128'(1));
        wb_cmd_val = 1'b1; wb_cmd_adr = 32'h00020000; wb_cmd_we = 1'b0; wb_cmd_sel = 4'hF;
        @(negedge clk);
        wb_cmd_val = 1'b0;
        chk("rst_mid/strobe", 128'(slv_cmd_val), 128'(4'b0010));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid/no_ack_before", 128'(wb_rd_ack), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) m_cfg[i] = 32'h0;
        m_tmo = 1'b0; m_dec = 1'b0;
        chk("rst_mid/rdy_after", 128'({cmd_rdy, wb_rd_ack, slv_cmd_val}), 128'({1'b1, 1'b0, 4'b0}));
        slv_rd_ack = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid/late_ack_ignored", 128'({wb_rd_ack, cmd_rdy}), 128'(2'b01));
        end
        slv_rd_ack = '0;
        chk("rst_mid/cfg_cleared", 128'(cfg_out), model_cfg());
        chk("rst_mid/errs_cleared", 128'({err_dec, err_tmo}), 128'({m_dec, m_tmo}));
        run_txn("post_rst_slv1", 32'h00020004, 1'b0, 4'hF, 32'h0, 1, 32'h0BADC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
